// File: rtl/bw_clk_seq_pkg.sv
// Shared types and helpers for the gclk-domain cluster clock-enable sequencer.
package bw_clk_seq_pkg;

    localparam logic [2:0] ENC_IDLE      = 3'd0;
    localparam logic [2:0] ENC_RAMP      = 3'd1;
    localparam logic [2:0] ENC_RST_WAIT  = 3'd2;
    localparam logic [2:0] ENC_DBG_WAIT  = 3'd3;
    localparam logic [2:0] ENC_RUN       = 3'd4;
    localparam logic [2:0] ENC_DBG_PULSE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = ENC_IDLE,
        ST_RAMP      = ENC_RAMP,
        ST_RST_WAIT  = ENC_RST_WAIT,
        ST_DBG_WAIT  = ENC_DBG_WAIT,
        ST_RUN       = ENC_RUN,
        ST_DBG_PULSE = ENC_DBG_PULSE
    } cken_seq_state_t;

    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bw_clk_seq_cnt.sv
// Loadable up-counter with synchronous clear; tc_o flags cnt == term_i while enabled.
// Clear wins over load, load wins over increment; all changes on the rising edge.
module bw_clk_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (load_i) cnt_d = load_val_i;
        else if (en_i)   cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tc_o = en_i && (cnt_q == term_i);

endmodule

// File: rtl/bw_clk_cken_seq.sv
// Staggered cluster clock-enable ramp, then grst_l/gdbginit_l release and rate-limited mask tracking in RUN.
// All outputs registered; debug-init sequencing (DBG_WAIT, DBG_PULSE, dbg_req) only with BW_CKEN_SEQ_DBGINIT_EN.
module bw_clk_cken_seq
    import bw_clk_seq_pkg::*;
#(
    parameter int NUM_CLUSTERS = 8,
    parameter int STAGGER      = 4,
    parameter int RST_DLY      = 16,
    parameter int DBG_DLY      = 8,
    parameter int DBG_PULSE    = 4
) (
    input  logic                    gclk,
    input  logic                    rst_l,
    input  logic [NUM_CLUSTERS-1:0] cken_mask,
    input  logic                    warm_rst_req,
    input  logic                    dbg_req,
    output logic [NUM_CLUSTERS-1:0] cluster_cken,
    output logic                    grst_l,
    output logic                    gdbginit_l,
    output logic                    seq_done,
    output logic                    busy
);

    localparam int CW = cnt_width(STAGGER, RST_DLY, DBG_DLY, DBG_PULSE);

    cken_seq_state_t         state_q, state_d;
    logic [NUM_CLUSTERS-1:0] cken_q, cken_d;
    logic                    grst_q, grst_d, gdbg_q, gdbg_d;
    logic                    done_q, done_d, busy_q, busy_d;
    logic                    stg_clr, stg_tc, dly_clr, dly_tc;
    logic [CW-1:0]           dly_term;
    logic [NUM_CLUSTERS-1:0] ramp_diff, ramp_pick, run_diff, run_pick;

    // x & -x isolates the lowest set bit, giving lowest-index-first priority
    assign ramp_diff = cken_mask & ~cken_q;
    assign ramp_pick = ramp_diff & (-ramp_diff);
    assign run_diff  = cken_mask ^ cken_q;
    assign run_pick  = run_diff & (-run_diff);

`ifndef BW_CKEN_SEQ_DBGINIT_EN
    logic unused_dbg_req;
    assign unused_dbg_req = dbg_req;
`endif

    always_comb begin
        state_d = state_q;
        cken_d  = cken_q;
        grst_d  = grst_q;
        gdbg_d  = gdbg_q;
        case (state_q)
            ST_IDLE: state_d = ST_RAMP;
            ST_RAMP: begin
                if (stg_tc) begin
                    if (|ramp_diff) cken_d  = cken_q | ramp_pick;
                    else            state_d = ST_RST_WAIT;
                end
            end
            ST_RST_WAIT: begin
                if (dly_tc) begin
                    grst_d = 1'b1;
`ifdef BW_CKEN_SEQ_DBGINIT_EN
                    state_d = ST_DBG_WAIT;
`else
                    state_d = ST_RUN;
`endif
                end
            end
`ifdef BW_CKEN_SEQ_DBGINIT_EN
            ST_DBG_WAIT: begin
                if (dly_tc) begin
                    gdbg_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_DBG_PULSE: begin
                if (stg_tc) cken_d = cken_q ^ run_pick;
                if (dly_tc) begin
                    gdbg_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                if (stg_tc) cken_d = cken_q ^ run_pick;
`ifdef BW_CKEN_SEQ_DBGINIT_EN
                if (dbg_req) begin
                    gdbg_d  = 1'b0;
                    state_d = ST_DBG_PULSE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // Warm reset overrides any tracking step or debug request on the same edge
        if (warm_rst_req && (state_q == ST_RUN || state_q == ST_DBG_PULSE)) begin
            state_d = ST_RST_WAIT;
            cken_d  = cken_q;
            grst_d  = 1'b0;
            gdbg_d  = 1'b0;
        end
`ifndef BW_CKEN_SEQ_DBGINIT_EN
        gdbg_d = grst_d;
`endif
        done_d = (state_d == ST_RUN);
        busy_d = !done_d;
    end

    always_comb begin
        dly_term = CW'(RST_DLY - 1);
        case (state_q)
            ST_DBG_WAIT:  dly_term = CW'(DBG_DLY - 1);
            ST_DBG_PULSE: dly_term = CW'(DBG_PULSE - 1);
            default:      dly_term = CW'(RST_DLY - 1);
        endcase
    end

    assign stg_clr = stg_tc || !(state_q inside {ST_RAMP, ST_RUN, ST_DBG_PULSE});
    assign dly_clr = (state_d != state_q) || !(state_q inside {ST_RST_WAIT, ST_DBG_WAIT, ST_DBG_PULSE});

    bw_clk_seq_cnt #(.W(CW)) u_stg_cnt (
        .clk_i      (gclk),
        .rst_ni     (rst_l),
        .clr_i      (stg_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (1'b1),
        .term_i     (CW'(STAGGER - 1)),
        .tc_o       (stg_tc)
    );

    bw_clk_seq_cnt #(.W(CW)) u_dly_cnt (
        .clk_i      (gclk),
        .rst_ni     (rst_l),
        .clr_i      (dly_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (1'b1),
        .term_i     (dly_term),
        .tc_o       (dly_tc)
    );

    always_ff @(posedge gclk) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
            cken_q  <= '0;
            grst_q  <= 1'b0;
            gdbg_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cken_q  <= cken_d;
            grst_q  <= grst_d;
            gdbg_q  <= gdbg_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign cluster_cken = cken_q;
    assign grst_l       = grst_q;
    assign gdbginit_l   = gdbg_q;
    assign seq_done     = done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_bw_clk_cken_seq.sv
// Self-checking bench for bw_clk_cken_seq: directed timing scenarios plus randomized RUN traffic against a timeline model.
module tb_bw_clk_cken_seq;

    localparam int N   = 8;
    localparam int STG = 4;
    localparam int RD  = 16;
    localparam int DD  = 8;
    localparam int DP  = 4;
`ifdef BW_CKEN_SEQ_DBGINIT_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif
    localparam int GDLY  = DBG_EN ? DD : 0;
    localparam int GRST_T = STG * (N + 1) + RD;
    localparam int RUN_T  = GRST_T + GDLY;

    logic         gclk = 1'b0;
    logic         rst_l;
    logic [N-1:0] cken_mask;
    logic         warm_rst_req;
    logic         dbg_req;
    logic [N-1:0] cluster_cken;
    logic         grst_l, gdbginit_l, seq_done, busy;
    logic [N+3:0] obs;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;
    int e0;

    logic [N-1:0] m_cken;
    int           m_run_e;
    int           m_dbg_end;

    always #5 gclk = ~gclk;

    bw_clk_cken_seq #(
        .NUM_CLUSTERS(N), .STAGGER(STG), .RST_DLY(RD), .DBG_DLY(DD), .DBG_PULSE(DP)
    ) dut (
        .gclk         (gclk),
        .rst_l        (rst_l),
        .cken_mask    (cken_mask),
        .warm_rst_req (warm_rst_req),
        .dbg_req      (dbg_req),
        .cluster_cken (cluster_cken),
        .grst_l       (grst_l),
        .gdbginit_l   (gdbginit_l),
        .seq_done     (seq_done),
        .busy         (busy)
    );

    assign obs = {cluster_cken, grst_l, gdbginit_l, seq_done, busy};

    task automatic tick();
        @(posedge gclk);
        #1;
        ecnt++;
    endtask

    function automatic logic [N-1:0] low_bits(input int n);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (i < n) v[i] = 1'b1;
        return v;
    endfunction

    // RUN-phase timeline: enables step on every STG-th edge after RUN entry, one bit toward the mask
    task automatic model_edge(input int e, input logic [N-1:0] mask, input logic dbg);
        if (e > m_run_e && (e - m_run_e) % STG == 0) begin
            for (int i = 0; i < N; i++) begin
                if (mask[i] != m_cken[i]) begin
                    m_cken[i] = mask[i];
                    break;
                end
            end
        end
        if (DBG_EN && dbg && e > m_dbg_end) m_dbg_end = e + DP;
    endtask

    function automatic logic [N+3:0] m_exp(input int e);
        logic low;
        low = (e >= m_dbg_end - DP) && (e < m_dbg_end);
        return {m_cken, 1'b1, !low, !low, low};
    endfunction

    task automatic release_reset(input logic [N-1:0] mask);
        rst_l = 1'b0;
        tick();
        tick();
        cken_mask = mask;
        rst_l = 1'b1;
        tick();
        e0 = ecnt;
    endtask

    task automatic test_reset();
        logic [N+3:0] exp;
        rst_l = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        exp = {{N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1};
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs, exp);
        end
        checks++;
    endtask

    task automatic test_bringup_full();
        logic [N+3:0] exp;
        int n;
        release_reset('1);
        for (int t = 1; t <= RUN_T + 10; t++) begin
            tick();
            n = t / STG;
            exp = {low_bits(n), t >= GRST_T, t >= RUN_T, t >= RUN_T, t < RUN_T};
            if (obs !== exp) begin
                errors++;
                $display("FAIL bringup_full t=%0d: got %h expected %h", t, obs, exp);
            end
            checks++;
        end
        m_run_e   = e0 + RUN_T;
        m_dbg_end = m_run_e;
        m_cken    = '1;
    endtask

    task automatic test_run_mask();
        logic [N-1:0] prev, one;
        int last_chg, nbit, nchg;
        one = 1;
        for (int ph = 0; ph < 2; ph++) begin
            cken_mask = (ph == 0) ? 8'h0F : 8'hFF;
            prev = cluster_cken;
            last_chg = -1;
            nbit = 4;
            nchg = 0;
            for (int t = 0; t < 24; t++) begin
                tick();
                model_edge(ecnt, cken_mask, 1'b0);
                if (obs !== m_exp(ecnt)) begin
                    errors++;
                    $display("FAIL run_mask_step ph=%0d t=%0d: got %h expected %h", ph, t, obs, m_exp(ecnt));
                end
                checks++;
                if (cluster_cken !== prev) begin
                    if ((cluster_cken ^ prev) !== (one << nbit) || (last_chg >= 0 && ecnt - last_chg != STG)) begin
                        errors++;
                        $display("FAIL run_mask_order ph=%0d: changed %h after %0d edges, expected bit %0d after %0d",
                                 ph, cluster_cken ^ prev, ecnt - last_chg, nbit, STG);
                    end
                    checks++;
                    last_chg = ecnt;
                    nbit++;
                    nchg++;
                    prev = cluster_cken;
                end
            end
            if (nchg != 4) begin
                errors++;
                $display("FAIL run_mask_count ph=%0d: got %0d changes expected 4", ph, nchg);
            end
            checks++;
        end
    endtask

    task automatic test_dbg_pulse();
        logic [N-1:0] held;
        int low;
        held = cluster_cken;
        low = 0;
        dbg_req = 1'b1;
        tick();
        model_edge(ecnt, cken_mask, 1'b1);
        dbg_req = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (t > 0) begin
                tick();
                model_edge(ecnt, cken_mask, 1'b0);
            end
            if (obs !== m_exp(ecnt)) begin
                errors++;
                $display("FAIL dbg_pulse_step t=%0d: got %h expected %h", t, obs, m_exp(ecnt));
            end
            checks++;
            if (gdbginit_l === 1'b0) low++;
        end
        if (low != (DBG_EN ? DP : 0)) begin
            errors++;
            $display("FAIL dbg_pulse_width: got %0d low cycles expected %0d", low, DBG_EN ? DP : 0);
        end
        checks++;
        if (cluster_cken !== held) begin
            errors++;
            $display("FAIL dbg_pulse_cken: got %h expected %h", cluster_cken, held);
        end
        checks++;
    endtask

    task automatic test_warm_dbg();
        logic [N-1:0] held;
        logic [N+3:0] exp;
        held = cluster_cken;
        cken_mask = '0;
        warm_rst_req = 1'b1;
        dbg_req = 1'b1;
        tick();
        warm_rst_req = 1'b0;
        dbg_req = 1'b0;
        exp = {held, 1'b0, 1'b0, 1'b0, 1'b1};
        if (obs !== exp) begin
            errors++;
            $display("FAIL warm_entry: got %h expected %h", obs, exp);
        end
        checks++;
        for (int t = 1; t <= RD + GDLY + STG + 4; t++) begin
            dbg_req = (t == 5);
            tick();
            dbg_req = 1'b0;
            exp = {4'b0000, t >= RD, t >= RD + GDLY, t >= RD + GDLY, t < RD + GDLY};
            if (obs[3:0] !== exp[3:0]) begin
                errors++;
                $display("FAIL warm_ctrl t=%0d: got %b expected %b", t, obs[3:0], exp[3:0]);
            end
            checks++;
            if (t < RD + GDLY + STG && cluster_cken !== held) begin
                errors++;
                $display("FAIL warm_cken_held t=%0d: got %h expected %h", t, cluster_cken, held);
            end
            if (t < RD + GDLY + STG) checks++;
            if (t == RD + GDLY + STG && cluster_cken !== (held & (held - 1'b1))) begin
                errors++;
                $display("FAIL warm_cken_resume: got %h expected %h", cluster_cken, held & (held - 1'b1));
            end
            if (t == RD + GDLY + STG) checks++;
        end
    endtask

    task automatic test_zero_mask();
        logic [N+3:0] exp;
        release_reset('0);
        for (int t = 1; t <= STG + RD + GDLY + 6; t++) begin
            tick();
            exp = {{N{1'b0}}, t >= STG + RD, t >= STG + RD + GDLY, t >= STG + RD + GDLY, t < STG + RD + GDLY};
            if (obs !== exp) begin
                errors++;
                $display("FAIL zero_mask t=%0d: got %h expected %h", t, obs, exp);
            end
            checks++;
        end
    endtask

    task automatic test_rst_mid_ramp();
        logic [N+3:0] exp;
        release_reset('1);
        for (int t = 1; t <= 3 * STG + 1; t++) tick();
        if (cluster_cken !== low_bits(3)) begin
            errors++;
            $display("FAIL mid_ramp_three: got %h expected %h", cluster_cken, low_bits(3));
        end
        checks++;
        rst_l = 1'b0;
        exp = {{N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            tick();
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_ramp_reset i=%0d: got %h expected %h", i, obs, exp);
            end
            checks++;
        end
        rst_l = 1'b1;
        tick();
        for (int t = 1; t <= 2 * STG + 1; t++) begin
            tick();
            exp = {low_bits(t / STG), 1'b0, 1'b0, 1'b0, 1'b1};
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_ramp_restart t=%0d: got %h expected %h", t, obs, exp);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic dbg_s;
        release_reset('1);
        for (int t = 1; t <= RUN_T; t++) tick();
        if (seq_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_run_entry: got done=%b busy=%b expected done=1 busy=0", seq_done, busy);
        end
        checks++;
        m_run_e   = e0 + RUN_T;
        m_dbg_end = m_run_e;
        m_cken    = '1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) cken_mask = N'($urandom);
            dbg_s = ($urandom_range(0, 19) == 0);
            dbg_req = dbg_s;
            tick();
            dbg_req = 1'b0;
            model_edge(ecnt, cken_mask, dbg_s);
            if (obs !== m_exp(ecnt)) begin
                errors++;
                $display("FAIL random i=%0d: got %h expected %h", i, obs, m_exp(ecnt));
            end
            checks++;
        end
    endtask

    initial begin
        rst_l        = 1'b0;
        cken_mask    = '0;
        warm_rst_req = 1'b0;
        dbg_req      = 1'b0;
        test_reset();
        test_bringup_full();
        test_run_mask();
        test_dbg_pulse();
        test_warm_dbg();
        test_zero_mask();
        test_rst_mid_ramp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bw_clk_cken_seq.md
# bw_clk_cken_seq

Cluster clock-enable and reset sequencer in the gclk domain. Drives per-cluster `cluster_cken`, global `grst_l` and `gdbginit_l` into the cluster clock headers. Ramps cluster enables one at a time to limit di/dt, then releases reset and debug-init in order. After bring-up it rate-limits enable-mask changes and serves warm-reset and debug-init requests.

## Interface
- `NUM_CLUSTERS`, 8: number of cluster headers driven; must be 1..32.
- `STAGGER`, 4: cycles between successive single-bit `cluster_cken` changes; must be ≥1.
- `RST_DLY`, 16: cycles from ramp completion to `grst_l` release; must be ≥1.
- `DBG_DLY`, 8: cycles from `grst_l` release to `gdbginit_l` release; must be ≥1.
- `DBG_PULSE`, 4: low width of a requested `gdbginit_l` pulse; must be ≥1.

Ports:
- `gclk` input 1: the only clock; all state changes on its rising edge.
- `rst_l` input 1: synchronous, active-low reset.
- `cken_mask` input NUM_CLUSTERS: target enable per cluster; level, sampled every cycle.
- `warm_rst_req` input 1: single-cycle warm-reset request.
- `dbg_req` input 1: single-cycle debug-init pulse request.
- `cluster_cken` output NUM_CLUSTERS: per-cluster clock enable.
- `grst_l` output 1: global reset to the headers, active-low.
- `gdbginit_l` output 1: global debug-init to the headers, active-low.
- `seq_done` output 1: high while in RUN.
- `busy` output 1: high in any state other than RUN.

## Operation
- Reset values while `rst_l`=0: `cluster_cken`=0, `grst_l`=0, `gdbginit_l`=0, `seq_done`=0, `busy`=1; state IDLE; counter=0.
- FSM states are IDLE, RAMP, RST_WAIT, DBG_WAIT, RUN and DBG_PULSE.
- IDLE→RAMP on the first edge with `rst_l`=1.
- RAMP:
  - The stagger counter counts 0..STAGGER-1.
  - At terminal count, set the lowest-index bit that is set in `cken_mask` and clear in `cluster_cken`.
  - When no such bit exists at terminal count, go to RST_WAIT. A zero mask therefore leaves RAMP after STAGGER cycles.
  - The mask is read live. Bits cleared during RAMP are not ramped down until RUN.
- RST_WAIT: count RST_DLY cycles, then set `grst_l`=1 on the same edge as the transition to DBG_WAIT.
- DBG_WAIT: count DBG_DLY cycles, then set `gdbginit_l`=1, `seq_done`=1 and enter RUN on the same edge.
- RUN:
  - Every STAGGER cycles, at most one bit of `cluster_cken` moves toward `cken_mask`. The lowest-index differing bit moves first.
  - The stagger counter free-runs.
- `dbg_req` in RUN: on the next edge `gdbginit_l`=0 and the state becomes DBG_PULSE. `gdbginit_l` returns to 1 after exactly DBG_PULSE cycles low, and the state returns to RUN. `cken` tracking continues in DBG_PULSE.
- `dbg_req` outside RUN is ignored and never queued.
- `warm_rst_req` in RUN or DBG_PULSE:
  - Next edge: `grst_l`=0, `gdbginit_l`=0, `seq_done`=0, state RST_WAIT with counter cleared.
  - `cluster_cken` is held during the warm reset. It is not re-ramped and is not tracked until RUN.
- `warm_rst_req` outside RUN and DBG_PULSE is ignored.
- Simultaneous `warm_rst_req` and `dbg_req`: the warm reset wins and `dbg_req` is dropped.
- `rst_l`=0 in any state returns all outputs to their reset values on that edge.

## Timing
- Reset release edge = E0. With all mask bits set, the k-th cluster enable (k from 0) rises at edge E0+STAGGER·(k+1).
- With the defaults and a full mask:
  - last cluster enable at E0+32;
  - `grst_l` rises at E0+32+4+16 = E0+52;
  - `gdbginit_l` and `seq_done` rise at E0+60.
- Every output is registered. No combinational path runs from any input to any output.
- Counter width is $clog2(max(STAGGER,RST_DLY,DBG_DLY,DBG_PULSE)+1).

## Configuration
- `BW_CKEN_SEQ_DBGINIT_EN` defined:
  - `dbg_req`, DBG_WAIT and DBG_PULSE are present as described above.
- `BW_CKEN_SEQ_DBGINIT_EN` undefined:
  - `gdbginit_l` is a registered copy of the `grst_l` next-state, so both rise on the same edge.
  - DBG_WAIT and DBG_PULSE are removed; RST_WAIT goes straight to RUN.
  - `dbg_req` is ignored.

## Structure
- Shared package `bw_clk_seq_pkg`:
  - state enum `cken_seq_state_t`;
  - a function returning the counter width;
  - localparam encodings.
- One sub-module, `bw_clk_seq_cnt`: loadable up-counter with synchronous clear and a terminal-count output. It is shared by the stagger, RST_DLY, DBG_DLY and DBG_PULSE timing.
- The lowest-differing-bit priority pick stays inline in the top level.

## Test plan
- Defaults, mask=8'hFF, release reset at E0:
  - `cken` rises one bit at a time at E0+4, 8, …, 32;
  - `grst_l` rises at E0+52;
  - `gdbginit_l` and `seq_done` rise at E0+60.
- Mask=8'h00:
  - `cken` stays 0;
  - `grst_l` rises at E0+20;
  - `gdbginit_l` rises at E0+28.
- In RUN, mask changes 8'hFF→8'h0F: bits 4, 5, 6 and 7 clear at 4-cycle spacing, lowest index first. A change back to 8'hFF ramps them up in the same order.
- `dbg_req` pulse in RUN: `gdbginit_l` is low for exactly 4 cycles and `cken` is unchanged. `dbg_req` during RST_WAIT has no effect.
- `warm_rst_req` and `dbg_req` in the same RUN cycle:
  - next edge: `grst_l`=0, `gdbginit_l`=0, `cken` held;
  - `grst_l` high 16 cycles later, `gdbginit_l` high 8 cycles after that;
  - no debug pulse is issued.
- `rst_l` dropped mid-RAMP with 3 bits enabled: all outputs return to their reset values on that edge. Re-release restarts the ramp from bit 0.
